// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - splices an immediate into an instruction word, one-entry output stage with address counter
// Optional range checking with out_err/err_cnt is enabled by defining IMM_RANGE_CHECK_EN.
module imm_encoder #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            ImmSel,
  input  logic [31:0]           imm,
  input  logic [31:0]           base,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  out_err,
  output logic [7:0]            err_cnt
);

  localparam logic [2:0] SEL_U = 3'b001;
  localparam logic [2:0] SEL_S = 3'b010;
  localparam logic [2:0] SEL_J = 3'b011;
  localparam logic [2:0] SEL_B = 3'b111;

  logic                  out_valid_q, out_valid_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           enc;
  logic                  accept, handshake;

  assign in_ready  = !out_valid_q || out_ready;
  assign handshake = out_valid_q && out_ready;
  assign accept    = in_valid && in_ready && !flush;

  // Load, I-type and the undefined selects all share the I layout via default
  always_comb begin
    enc = base;
    case (ImmSel)
      SEL_U: enc[31:12] = imm[31:12];
      SEL_S: begin
        enc[31:25] = imm[11:5];
        enc[11:7]  = imm[4:0];
      end
      SEL_J: begin
        enc[31]    = imm[20];
        enc[30:21] = imm[10:1];
        enc[20]    = imm[11];
        enc[19:12] = imm[19:12];
      end
      SEL_B: begin
        enc[31]    = imm[12];
        enc[30:25] = imm[10:5];
        enc[11:8]  = imm[4:1];
        enc[7]     = imm[11];
      end
      default: enc[31:20] = imm[11:0];
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    if (flush) begin
      out_valid_d = 1'b0;
      addr_d      = '0;
    end else begin
      if (handshake) begin
        out_valid_d = 1'b0;
        addr_d      = addr_q + ADDR_WIDTH'(4);
      end
      if (accept) begin
        out_valid_d = 1'b1;
        instr_d     = enc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign addr      = addr_q;

`ifdef IMM_RANGE_CHECK_EN
  logic       range_err;
  logic       out_err_q, out_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // A value fits an N-bit signed field when all bits from N-1 upward agree
  always_comb begin
    case (ImmSel)
      SEL_U:   range_err = |imm[11:0];
      SEL_J:   range_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      SEL_B:   range_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      default: range_err = !((&imm[31:11]) || !(|imm[31:11]));
    endcase
  end

  always_comb begin
    out_err_d = out_err_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      out_err_d = range_err;
      if (range_err && err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      out_err_q <= out_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_err = out_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign out_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder
`timescale 1ns/1ps
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  ImmSel;
  logic [31:0] imm, base, instr, addr;
  logic [7:0]  err_cnt;

  imm_encoder #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSel(ImmSel), .imm(imm), .base(base), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .addr(addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          m_valid;
  logic [31:0] m_addr;
  int          m_errcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [2:0] sel, input logic [31:0] im, input logic [31:0] b);
    case (sel)
      3'b001:  return (b & 32'h00000FFF) | (im & 32'hFFFFF000);
      3'b010:  return (b & 32'h01FFF07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
      3'b011:  return (b & 32'h00000FFF) | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 32'h1) << 20) | (im & 32'h000FF000);
      3'b111:  return (b & 32'h01FFF07F) | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                      | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
      default: return (b & 32'h000FFFFF) | (im << 20);
    endcase
  endfunction

  function automatic bit model_err(input logic [2:0] sel, input logic [31:0] im);
`ifdef IMM_RANGE_CHECK_EN
    int si;
    si = int'(im);
    case (sel)
      3'b001:  return (im & 32'hFFF) != 0;
      3'b011:  return im[0] || si < -(1 << 20) || si > (1 << 20) - 1;
      3'b111:  return im[0] || si < -4096 || si > 4095;
      default: return si < -2048 || si > 2047;
    endcase
`else
    return (sel == 3'b000) && (im == 32'h1) && 1'b0;
`endif
  endfunction

  // Drive one cycle at the current negedge; compare the visible output, then update the model
  task automatic req(input bit v, input logic [2:0] sel, input logic [31:0] im, input logic [31:0] b,
                     input bit ordy, input bit fl);
    exp_t e;
    bit   acc, hs;
    in_valid = v; ImmSel = sel; imm = im; base = b; out_ready = ordy; flush = fl;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || ordy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("err_cnt", {24'd0, err_cnt}, m_errcnt);
    if (m_valid && sb.size() != 0) begin
      check("instr", instr, sb[0].instr);
      check("addr", addr, m_addr);
      check("out_err", {31'd0, out_err}, {31'd0, sb[0].err});
    end
    hs  = m_valid && ordy;
    acc = v && (!m_valid || ordy) && !fl;
    if (fl) begin
      m_valid = 1'b0;
      m_addr  = '0;
      sb.delete();
    end else begin
      if (hs) begin
        void'(sb.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (acc) begin
        e.instr = model_enc(sel, im, b);
        e.err   = model_err(sel, im);
        sb.push_back(e);
        if (e.err && m_errcnt < 255) m_errcnt++;
      end
      m_valid = acc ? 1'b1 : (hs ? 1'b0 : m_valid);
    end
    @(negedge clk);
  endtask

  task automatic check_now(input string tag, input logic [31:0] e_instr, input logic [31:0] e_addr);
    check({tag, "_instr"}, instr, e_instr);
    check({tag, "_addr"}, addr, e_addr);
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_addr   = '0;
    m_errcnt = 0;
    sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bnd[12];
    logic [2:0]  sel;
    logic [31:0] im;
    bnd = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094, -32'sd4096,
            32'd4096, 32'h000FFFFE, 32'hFFF00000, 32'h00100000, 32'd3, 32'h00ABC000};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    ImmSel = 3'b000; imm = 32'd5; base = 32'h93;
    model_reset();
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("no_accept_in_rst", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    req(1, 3'b000, 32'd5, 32'h00000093, 1, 0);          check_now("i_pos", 32'h00500093, 32'd0);
    req(1, 3'b000, -32'sd1, 32'h00000093, 1, 0);        check_now("i_neg", 32'hFFF00093, 32'd4);
    req(1, 3'b010, 32'd8, 32'h0020A023, 1, 0);          check_now("s", 32'h0020A423, 32'd8);
    req(1, 3'b111, -32'sd4, 32'h00000063, 1, 0);        check_now("b", 32'hFE000EE3, 32'd12);
    req(1, 3'b011, 32'd8, 32'h0000006F, 1, 0);          check_now("j", 32'h0080006F, 32'd16);
    req(1, 3'b001, 32'h12345000, 32'h00000037, 1, 0);   check_now("u", 32'h12345037, 32'd20);
    req(1, 3'b000, 32'd2048, 32'h00000093, 1, 0);       check_now("i_ovf", 32'h80000093, 32'd24);
`ifdef IMM_RANGE_CHECK_EN
    check("ovf_err", {31'd0, out_err}, 32'd1);
    check("ovf_cnt", {24'd0, err_cnt}, 32'd1);
`else
    check("ovf_err", {31'd0, out_err}, 32'd0);
    check("ovf_cnt", {24'd0, err_cnt}, 32'd0);
`endif
    req(1, 3'b101, 32'd7, 32'h00000013, 1, 0);          check_now("sel101", 32'h00700013, 32'd28);

    // Stall three cycles, then drain and accept in the same cycle
    for (int i = 0; i < 3; i++) req(1, 3'b110, 32'd9, 32'h13, 0, 0);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    req(1, 3'b110, 32'd9, 32'h00000013, 1, 0);          check_now("after_stall", 32'h00900013, 32'd32);

    // Asynchronous reset in the middle of a stall
    req(1, 3'b000, 32'd1, 32'h13, 0, 0);
    in_valid = 1'b1; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_addr", addr, 32'd0);
    check("arst_instr", instr, 32'd0);
    check("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    #1 check("arst_no_accept", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    req(1, 3'b000, 32'd3, 32'h00000093, 1, 0);          check_now("first_after_rst", 32'h00300093, 32'd0);

    // Flush with a simultaneous request
    req(1, 3'b000, 32'd4, 32'h93, 1, 0);
    req(1, 3'b000, 32'd6, 32'h93, 1, 1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_addr", addr, 32'd0);

    for (int i = 0; i < 160; i++) begin
      sel = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       im = bnd[$urandom_range(0, 11)];
        1:       im = 32'($signed(12'($urandom)));
        default: im = $urandom;
      endcase
      req(($urandom_range(0, 3) != 0), sel, im, $urandom, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 19) == 0));
    end

    // Drive enough erroring requests to saturate err_cnt, then flush it must survive
    for (int i = 0; i < 260; i++) req(1, 3'b000, 32'd4096, 32'h93, 1, 0);
    req(0, 3'b000, 32'd0, 32'h0, 1, 1);
    req(0, 3'b000, 32'd0, 32'h0, 1, 0);
`ifdef IMM_RANGE_CHECK_EN
    check("err_sat", {24'd0, err_cnt}, 32'd255);
`else
    check("err_sat", {24'd0, err_cnt}, 32'd0);
`endif
    req(0, 3'b000, 32'd0, 32'h0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
